// File: rtl/aes_round_ctrl_pkg.sv
// Shared definitions for the AES round sequencer: state encoding, key size codes
// and round counts per key size.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_KEYEXP = 3'd1,
    ST_INIT   = 3'd2,
    ST_ROUND  = 3'd3,
    ST_FINAL  = 3'd4,
    ST_DONE   = 3'd5
  } aes_state_e;

  typedef enum logic [1:0] {
    KS_128 = 2'b00,
    KS_192 = 2'b01,
    KS_256 = 2'b10,
    KS_RSV = 2'b11
  } aes_ks_e;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

  // Reserved key size code falls back to the AES-128 round count.
  function automatic int nr_of(input logic [1:0] ks);
    case (ks)
      KS_192:  return AES_NR_192;
      KS_256:  return AES_NR_256;
      default: return AES_NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Command, key-expansion and result handshake bundle between the GCM scheduler
// (master) and the AES round controller (slave).
interface aes_round_ctrl_if #(parameter int CNT_SIZE = 4);

  logic                i_start;
  logic                o_ready;
  logic [1:0]          i_key_size;
  logic                i_key_new;
  logic                o_key_exp_start;
  logic                i_key_exp_done;
  logic                o_round_en;
  logic [CNT_SIZE-1:0] o_round_idx;
  logic                o_first_round;
  logic                o_last_round;
  logic                o_valid;
  logic                i_out_ready;
  logic                o_busy;
  logic                o_err;
  logic                i_flush;

  modport master (
    output i_start, i_key_size, i_key_new, i_key_exp_done, i_out_ready, i_flush,
    input  o_ready, o_key_exp_start, o_round_en, o_round_idx, o_first_round,
           o_last_round, o_valid, o_busy, o_err
  );

  modport slave (
    input  i_start, i_key_size, i_key_new, i_key_exp_done, i_out_ready, i_flush,
    output o_ready, o_key_exp_start, o_round_en, o_round_idx, o_first_round,
           o_last_round, o_valid, o_busy, o_err
  );

endinterface

// File: rtl/aes_round_ctrl_counter.sv
// Round index counter: synchronous clear beats enable; terminal flag compares
// against a value supplied by the sequencer.
module aes_round_counter #(
  parameter int CNT_SIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_clr,
  input  logic                i_en,
  input  logic [CNT_SIZE-1:0] i_term_val,
  output logic [CNT_SIZE-1:0] o_cnt,
  output logic                o_term
);

  logic [CNT_SIZE-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= r_cnt + CNT_SIZE'(1);
  end

  assign o_cnt  = r_cnt;
  assign o_term = (r_cnt == i_term_val);

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES round datapath: accepts one encrypt command,
// optionally runs key expansion, then steps INIT / ROUND / FINAL and holds DONE.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int CNT_SIZE = 4,
  parameter int NR_128   = AES_NR_128,
  parameter int NR_192   = AES_NR_192,
  parameter int NR_256   = AES_NR_256
) (
  input  logic             clk,
  input  logic             rst,
  aes_round_ctrl_if.slave  bus
);

  aes_state_e          r_state;
  logic [CNT_SIZE-1:0] r_nr;
  logic                r_ready;
  logic                r_busy;
  logic                r_valid;
  logic                r_err;
  logic                r_kexp;
  logic                r_first;
  logic                r_last;
  logic                r_round_en;

  logic                w_accept;
  logic                w_cnt_clr;
  logic                w_cnt_en;
  logic                w_term;
  logic [CNT_SIZE-1:0] w_term_val;
  logic [CNT_SIZE-1:0] w_idx;

  function automatic logic [CNT_SIZE-1:0] nr_sel(input logic [1:0] ks);
    case (ks)
      KS_192:  return CNT_SIZE'(NR_192);
      KS_256:  return CNT_SIZE'(NR_256);
      default: return CNT_SIZE'(NR_128);
    endcase
  endfunction

  // The counter moves in lockstep with the state: cleared on accept, DONE handshake
  // or flush, incremented on the edges leaving INIT and each ROUND cycle.
  assign w_accept   = (r_state == ST_IDLE) & bus.i_start & ~bus.i_flush;
  assign w_cnt_clr  = bus.i_flush | w_accept | ((r_state == ST_DONE) & bus.i_out_ready);
  assign w_cnt_en   = ~bus.i_flush & ((r_state == ST_INIT) | (r_state == ST_ROUND));
  assign w_term_val = r_nr - CNT_SIZE'(1);

  aes_round_counter #(.CNT_SIZE(CNT_SIZE)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_cnt_clr),
    .i_en       (w_cnt_en),
    .i_term_val (w_term_val),
    .o_cnt      (w_idx),
    .o_term     (w_term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_nr       <= CNT_SIZE'(NR_128);
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_kexp     <= 1'b0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_round_en <= 1'b0;
    end else begin
      r_err      <= 1'b0;
      r_kexp     <= 1'b0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_round_en <= 1'b0;
      if (bus.i_flush) begin
        r_state <= ST_IDLE;
        r_ready <= 1'b1;
        r_busy  <= 1'b0;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.i_start) begin
              r_nr    <= nr_sel(bus.i_key_size);
              r_err   <= (bus.i_key_size == KS_RSV);
              r_ready <= 1'b0;
              r_busy  <= 1'b1;
              if (bus.i_key_new) begin
                r_state <= ST_KEYEXP;
                r_kexp  <= 1'b1;
              end else begin
                r_state    <= ST_INIT;
                r_first    <= 1'b1;
                r_round_en <= 1'b1;
              end
            end
          end
          ST_KEYEXP: begin
            if (bus.i_key_exp_done) begin
              r_state    <= ST_INIT;
              r_first    <= 1'b1;
              r_round_en <= 1'b1;
            end
          end
          ST_INIT: begin
            r_state    <= ST_ROUND;
            r_round_en <= 1'b1;
          end
          ST_ROUND: begin
            r_round_en <= 1'b1;
            if (w_term) begin
              r_state <= ST_FINAL;
              r_last  <= 1'b1;
            end
          end
          ST_FINAL: begin
            r_state <= ST_DONE;
            r_valid <= 1'b1;
          end
          ST_DONE: begin
            // Ready stays low through the handshake edge, so no back-to-back accept.
            if (bus.i_out_ready) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_ready <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.o_ready         = r_ready;
  assign bus.o_busy          = r_busy;
  assign bus.o_valid         = r_valid;
  assign bus.o_err           = r_err;
  assign bus.o_key_exp_start = r_kexp;
  assign bus.o_first_round   = r_first;
  assign bus.o_last_round    = r_last;
  assign bus.o_round_en      = r_round_en;
  assign bus.o_round_idx     = w_idx;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: the driver pushes the expected round trace
// and result timing per command, a negedge monitor pops and compares.
module tb_aes_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_round_ctrl_if #(.CNT_SIZE(4)) bus ();

  aes_round_ctrl #(.CNT_SIZE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int idx; int first; int last; int cyc;} rnd_t;
  typedef struct {int nr; int vcyc;} res_t;
  rnd_t rq[$];
  res_t resq[$];
  bit   vseen      = 1'b0;
  bit   expect_rdy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_nr(input int ks);
    if (ks == 1) return 12;
    if (ks == 2) return 14;
    return 10;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input int nr, input int init);
    for (int r = 0; r <= nr; r++)
      rq.push_back('{r, int'(r == 0), int'(r == nr), init + r});
    resq.push_back('{nr, init + nr + 1});
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bus.o_ready && n < 100) begin
      tick();
      n++;
    end
    chk("wait_ready_timeout", bus.o_ready, 1);
  endtask

  task automatic wait_idle(input int pct);
    int n = 0;
    while (bus.o_busy && n < 300) begin
      bus.i_out_ready = ($urandom_range(99) < pct);
      tick();
      n++;
    end
    chk("cmd_done_timeout", bus.o_busy, 0);
  endtask

  task automatic run_cmd(input int ks, input int kn, input int dly, input int pct, input int flush_at);
    int nr;
    int init;
    int n;
    wait_ready();
    bus.i_start     = 1'b1;
    bus.i_key_size  = 2'(ks);
    bus.i_key_new   = kn[0];
    bus.i_out_ready = ($urandom_range(99) < pct);
    tick();
    bus.i_start    = 1'b0;
    bus.i_key_size = 2'($urandom);
    nr = model_nr(ks);
    chk("err_pulse", bus.o_err, int'(ks == 3));
    chk("kexp_pulse", bus.o_key_exp_start, kn);
    if (kn != 0) begin
      for (int k = 0; k < dly; k++) begin
        tick();
        chk("kexp_single", bus.o_key_exp_start, 0);
        chk("kexp_no_round", bus.o_round_en, 0);
        chk("err_one_cycle", bus.o_err, 0);
      end
      bus.i_key_exp_done = 1'b1;
      tick();
      bus.i_key_exp_done = 1'b0;
    end
    init = cyc;
    push_cmd(nr, init);
    n = 0;
    while (bus.o_busy && n < 300) begin
      if (flush_at >= 0 && bus.o_round_en && bus.o_round_idx == flush_at) begin
        bus.i_flush = 1'b1;
        tick();
        bus.i_flush = 1'b0;
        rq.delete();
        resq.delete();
        vseen = 1'b0;
        chk("flush_ready", bus.o_ready, 1);
        chk("flush_idx", bus.o_round_idx, 0);
        chk("flush_round_en", bus.o_round_en, 0);
        chk("flush_valid", bus.o_valid, 0);
        break;
      end
      bus.i_out_ready = ($urandom_range(99) < pct);
      tick();
      n++;
    end
    chk("cmd_done_timeout", bus.o_busy, 0);
  endtask

  // Monitor
  initial begin
    rnd_t r;
    res_t s;
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("strobe_excl",
            int'(($countones({bus.o_first_round, bus.o_last_round, bus.o_valid, bus.o_key_exp_start}) <= 1)
                 && (!bus.o_first_round || bus.o_round_en)
                 && (!bus.o_last_round || bus.o_round_en)
                 && !(bus.o_valid && bus.o_round_en)), 1);
        chk("ready_vs_busy", bus.o_ready, int'(!bus.o_busy));
        if (expect_rdy) begin
          expect_rdy = 1'b0;
          chk("ready_after_hs", bus.o_ready, 1);
          chk("idx_zero_idle", bus.o_round_idx, 0);
        end
        if (rq.size() == 0) begin
          if (bus.o_round_en) chk("spurious_round_en", bus.o_round_en, 0);
        end else if (bus.o_round_en) begin
          r = rq.pop_front();
          chk("round_idx", bus.o_round_idx, r.idx);
          chk("round_first", bus.o_first_round, r.first);
          chk("round_last", bus.o_last_round, r.last);
          chk("round_cycle", cyc, r.cyc);
        end
        if (resq.size() == 0) begin
          if (bus.o_valid) chk("spurious_valid", bus.o_valid, 0);
        end else if (bus.o_valid) begin
          s = resq[0];
          if (!vseen) begin
            vseen = 1'b1;
            chk("valid_cycle", cyc, s.vcyc);
            chk("round_en_count_left", rq.size(), 0);
          end
          chk("valid_idx_hold", bus.o_round_idx, s.nr);
          chk("valid_ready_low", bus.o_ready, 0);
          if (bus.i_out_ready && !bus.i_flush) begin
            void'(resq.pop_front());
            vseen      = 1'b0;
            expect_rdy = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int n;
    int init;
    bus.i_start        = 1'b0;
    bus.i_key_size     = 2'b00;
    bus.i_key_new      = 1'b0;
    bus.i_key_exp_done = 1'b0;
    bus.i_out_ready    = 1'b0;
    bus.i_flush        = 1'b0;
    tick();
    chk("rst_ready", bus.o_ready, 1);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_idx", bus.o_round_idx, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_round_en", bus.o_round_en, 0);
    rst = 1'b0;
    tick();

    run_cmd(0, 0, 0, 100, -1);
    run_cmd(2, 1, 5, 100, -1);

    // Backpressure on AES-192 with a second command held on i_start during DONE
    wait_ready();
    bus.i_start = 1'b1; bus.i_key_size = 2'b01; bus.i_key_new = 1'b0; bus.i_out_ready = 1'b0;
    tick();
    bus.i_start = 1'b0;
    init = cyc;
    push_cmd(12, init);
    n = 0;
    while (!bus.o_valid && n < 100) begin
      tick();
      n++;
    end
    chk("bp_valid_timeout", bus.o_valid, 1);
    for (int k = 0; k < 7; k++) begin
      if (k == 2) begin
        bus.i_start = 1'b1; bus.i_key_size = 2'b10;
      end
      chk("bp_valid_held", bus.o_valid, 1);
      chk("bp_idx_held", bus.o_round_idx, 12);
      tick();
    end
    bus.i_out_ready = 1'b1;
    chk("bp_ready_low_done", bus.o_ready, 0);
    tick();
    chk("bp_ready_after_hs", bus.o_ready, 1);
    chk("bp_busy_after_hs", bus.o_busy, 0);
    tick();
    bus.i_start = 1'b0;
    push_cmd(14, cyc);
    chk("bp_second_accept", bus.o_busy, 1);
    wait_idle(100);

    run_cmd(2, 0, 0, 100, 5);
    run_cmd(3, 0, 0, 100, -1);

    wait_ready();
    bus.i_start = 1'b1; bus.i_flush = 1'b1; bus.i_key_size = 2'b00;
    tick();
    bus.i_start = 1'b0; bus.i_flush = 1'b0;
    chk("flush_start_no_accept", bus.o_busy, 0);
    tick();
    chk("flush_start_no_round", bus.o_round_en, 0);

    // Asynchronous reset while waiting in key expansion
    wait_ready();
    bus.i_start = 1'b1; bus.i_key_size = 2'b10; bus.i_key_new = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("rstk_kexp_pulse", bus.o_key_exp_start, 1);
    tick();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rstk_ready", bus.o_ready, 1);
    chk("rstk_busy", bus.o_busy, 0);
    chk("rstk_idx", bus.o_round_idx, 0);
    chk("rstk_kexp", bus.o_key_exp_start, 0);
    tick();
    rst = 1'b0;
    bus.i_key_exp_done = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rstk_done_ignored_busy", bus.o_busy, 0);
      chk("rstk_done_ignored_round", bus.o_round_en, 0);
    end
    bus.i_key_exp_done = 1'b0;
    run_cmd(1, 1, 2, 70, -1);

    for (int i = 0; i < 12; i++)
      run_cmd($urandom_range(3), $urandom_range(1), $urandom_range(6), $urandom_range(100, 40), -1);

    tick();
    tick();
    chk("rq_drained", rq.size(), 0);
    chk("resq_drained", resq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
